// File: rtl/key_event_decoder.sv
// key_event_decoder: classifies debounced press/release pulses into
// short / long / double gestures. Optional auto-repeat: KEY_REPEAT_EN.
module key_event_decoder #(
  parameter logic [25:0] T_LONG = 26'd50_000_000,
  parameter logic [25:0] T_DBL  = 26'd15_000_000,
  parameter logic [25:0] T_REP  = 26'd10_000_000
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       PRESS,
  input  logic       RELEASE,
  output logic       SHORT,
  output logic       LONG,
  output logic       DOUBLE,
  output logic [1:0] LED
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HELD1,
    S_LONG_HELD,
    S_WAIT2,
    S_HELD2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [25:0] r_cnt;
  logic        w_short;
  logic        w_long;
  logic        w_dbl;
  logic        w_rep;
  logic        w_timed;

`ifndef KEY_REPEAT_EN
  // T_REP only matters when auto-repeat is built in
  logic w_unused_rep;
  assign w_unused_rep = ^T_REP;
`endif

  // state register
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // next-state and gesture decisions
  always_comb begin
    w_next  = r_state;
    w_short = 1'b0;
    w_long  = 1'b0;
    w_dbl   = 1'b0;
    w_rep   = 1'b0;
    w_timed = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (PRESS) w_next = S_HELD1;
      end
      S_HELD1: begin
        w_timed = 1'b1;
        if (RELEASE) begin
          w_next = S_WAIT2;
        end else if (r_cnt == T_LONG - 26'd1) begin
          w_long = 1'b1;
          w_next = S_LONG_HELD;
        end
      end
      S_LONG_HELD: begin
`ifdef KEY_REPEAT_EN
        w_timed = 1'b1;
        if (RELEASE) begin
          w_next = S_IDLE;
        end else if (r_cnt == T_REP - 26'd1) begin
          w_long = 1'b1;
          w_rep  = 1'b1;
        end
`else
        if (RELEASE) w_next = S_IDLE;
`endif
      end
      S_WAIT2: begin
        w_timed = 1'b1;
        if (PRESS) begin
          w_next = S_HELD2;
        end else if (r_cnt == T_DBL - 26'd1) begin
          w_short = 1'b1;
          w_next  = S_IDLE;
        end
      end
      S_HELD2: begin
        w_timed = 1'b1;
        if (RELEASE) begin
          w_dbl  = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // saturating timer, cleared on every state entry and on each repeat
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_cnt <= '0;
    end else if ((w_next != r_state) || w_rep) begin
      r_cnt <= '0;
    end else if (w_timed && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 26'd1;
    end
  end

  // registered gesture pulses and LED indicator
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      SHORT  <= 1'b0;
      LONG   <= 1'b0;
      DOUBLE <= 1'b0;
      LED    <= 2'b00;
    end else begin
      SHORT  <= w_short;
      LONG   <= w_long;
      DOUBLE <= w_dbl;
      LED    <= LED ^ {w_long | w_dbl, w_short | w_dbl};
    end
  end

endmodule
